id_ex_hazard_reg: RTL

Producer side of the ID->EX interface. Registers every datapath and control field consumed by the execute stage (IDtoEX_* bundle) and owns load-use hazard detection. On a hazard it stalls the front end and injects bubbles, and on a taken branch it flushes. Sits between the decode stage / register file and the execute stage; also registers Rs for the forwarding unit.

---
 rtl/id_ex_hazard_reg_pkg.sv | 32 +++
 rtl/id_ex_hazard_reg_if.sv | 50 +++++
 rtl/id_ex_hazard_reg_hazard_detect.sv | 32 +++
 rtl/id_ex_hazard_reg.sv | 109 ++++++++++
 4 files changed

// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared types for the ID->EX stage register: the execute control bundle, its bubble value and ALU op classes.
// Latency: none (types only); backpressure: none (types only).
package id_ex_hazard_reg_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;
  localparam int CW_DEF = 16;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  // An invalid decode slot must never carry side-effecting controls into EX.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic keep);
    return keep ? c : BUBBLE_CTRL;
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID->EX boundary: decode-side fields in, registered execute bundle and front-end hold/flush out.
// Latency: wires only; backpressure: front end holds via PCWrite/IFIDWrite.
interface id_ex_hazard_reg_if
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
);

  logic [DW-1:0] ID_PCadd4, ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [RW-1:0] ID_Rs, ID_Rt, ID_Rd;
  logic [5:0]    ID_funct;
  logic [1:0]    ID_ALUop;
  logic          ID_ALUSrc, ID_RegDst, ID_MemRead, ID_MemWrite;
  logic          ID_RegWrite, ID_MemtoReg, ID_Branch, ID_valid;
  logic          BranchTaken;

  logic [DW-1:0] IDtoEX_PCadd4, IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm;
  logic [RW-1:0] IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd;
  logic [5:0]    IDtoEX_funct;
  logic [1:0]    IDtoEX_ALUop;
  logic          IDtoEX_ALUSrc, IDtoEX_RegDst, IDtoEX_MemRead, IDtoEX_MemWrite;
  logic          IDtoEX_RegWrite, IDtoEX_MemtoReg, IDtoEX_Branch, IDtoEX_valid;
  logic          PCWrite, IFIDWrite, IFIDFlush;
  logic [CW-1:0] stall_count, flush_count;

  modport master (
    output ID_PCadd4, ID_ReadData1, ID_ReadData2, ID_Imm, ID_Rs, ID_Rt, ID_Rd,
           ID_funct, ID_ALUop, ID_ALUSrc, ID_RegDst, ID_MemRead, ID_MemWrite,
           ID_RegWrite, ID_MemtoReg, ID_Branch, ID_valid, BranchTaken,
    input  IDtoEX_PCadd4, IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm,
           IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd, IDtoEX_funct, IDtoEX_ALUop,
           IDtoEX_ALUSrc, IDtoEX_RegDst, IDtoEX_MemRead, IDtoEX_MemWrite,
           IDtoEX_RegWrite, IDtoEX_MemtoReg, IDtoEX_Branch, IDtoEX_valid,
           PCWrite, IFIDWrite, IFIDFlush, stall_count, flush_count
  );

  modport slave (
    input  ID_PCadd4, ID_ReadData1, ID_ReadData2, ID_Imm, ID_Rs, ID_Rt, ID_Rd,
           ID_funct, ID_ALUop, ID_ALUSrc, ID_RegDst, ID_MemRead, ID_MemWrite,
           ID_RegWrite, ID_MemtoReg, ID_Branch, ID_valid, BranchTaken,
    output IDtoEX_PCadd4, IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm,
           IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd, IDtoEX_funct, IDtoEX_ALUop,
           IDtoEX_ALUSrc, IDtoEX_RegDst, IDtoEX_MemRead, IDtoEX_MemWrite,
           IDtoEX_RegWrite, IDtoEX_MemtoReg, IDtoEX_Branch, IDtoEX_valid,
           PCWrite, IFIDWrite, IFIDFlush, stall_count, flush_count
  );

endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// Load-use hazard detection and front-end hold/flush controls.
// Latency: combinational; backpressure: a flush always releases the front end so the redirect proceeds.
module id_ex_hazard_reg_hazard_detect
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          reset_n,
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          branch_taken,
  output logic          load_use,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush
);

  logic rt_match;

  // $0 is hardwired zero, so a load targeting it never creates a real dependency.
  assign rt_match = (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign load_use = ex_valid && ex_mem_read && id_valid && rt_match;

  assign pc_write   = !load_use || branch_taken || !reset_n;
  assign ifid_write = pc_write;
  assign ifid_flush = branch_taken && reset_n;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID->EX pipeline register with load-use stall and branch flush bubble injection plus saturating event counters.
// Latency: 1 cycle ID->EX; backpressure: holds PC and IF/ID for one cycle on a load-use hazard.
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
) (
  input logic               clk,
  input logic               reset_n,
  id_ex_hazard_reg_if.slave bus
);

  logic [DW-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  logic [5:0]    funct_q;
  ctrl_t         ctrl_q;
  ctrl_t         id_ctrl;
  logic          valid_q;
  logic [CW-1:0] stall_q, flush_q;
  logic          load_use;

  assign id_ctrl = '{
    alu_op:     bus.ID_ALUop,
    alu_src:    bus.ID_ALUSrc,
    reg_dst:    bus.ID_RegDst,
    mem_read:   bus.ID_MemRead,
    mem_write:  bus.ID_MemWrite,
    reg_write:  bus.ID_RegWrite,
    mem_to_reg: bus.ID_MemtoReg,
    branch:     bus.ID_Branch
  };

  id_ex_hazard_reg_hazard_detect #(.RW(RW)) u_hazard (
    .reset_n      (reset_n),
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q.mem_read),
    .ex_rt        (rt_q),
    .id_valid     (bus.ID_valid),
    .id_rs        (bus.ID_Rs),
    .id_rt        (bus.ID_Rt),
    .branch_taken (bus.BranchTaken),
    .load_use     (load_use),
    .pc_write     (bus.PCWrite),
    .ifid_write   (bus.IFIDWrite),
    .ifid_flush   (bus.IFIDFlush)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      funct_q <= '0;
      ctrl_q  <= BUBBLE_CTRL;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      // Datapath fields are meaningless under a bubble, so they load unconditionally.
      pc_q    <= bus.ID_PCadd4;
      rd1_q   <= bus.ID_ReadData1;
      rd2_q   <= bus.ID_ReadData2;
      imm_q   <= bus.ID_Imm;
      rs_q    <= bus.ID_Rs;
      rt_q    <= bus.ID_Rt;
      rd_q    <= bus.ID_Rd;
      funct_q <= bus.ID_funct;
      if (bus.BranchTaken) begin
        ctrl_q  <= BUBBLE_CTRL;
        valid_q <= 1'b0;
        flush_q <= (&flush_q) ? flush_q : flush_q + 1'b1;
      end else if (load_use) begin
        ctrl_q  <= BUBBLE_CTRL;
        valid_q <= 1'b0;
        stall_q <= (&stall_q) ? stall_q : stall_q + 1'b1;
      end else begin
        ctrl_q  <= gate_ctrl(id_ctrl, bus.ID_valid);
        valid_q <= bus.ID_valid;
      end
    end
  end

  assign bus.IDtoEX_PCadd4    = pc_q;
  assign bus.IDtoEX_ReadData1 = rd1_q;
  assign bus.IDtoEX_ReadData2 = rd2_q;
  assign bus.IDtoEX_Imm       = imm_q;
  assign bus.IDtoEX_Rs        = rs_q;
  assign bus.IDtoEX_Rt        = rt_q;
  assign bus.IDtoEX_Rd        = rd_q;
  assign bus.IDtoEX_funct     = funct_q;
  assign bus.IDtoEX_ALUop     = ctrl_q.alu_op;
  assign bus.IDtoEX_ALUSrc    = ctrl_q.alu_src;
  assign bus.IDtoEX_RegDst    = ctrl_q.reg_dst;
  assign bus.IDtoEX_MemRead   = ctrl_q.mem_read;
  assign bus.IDtoEX_MemWrite  = ctrl_q.mem_write;
  assign bus.IDtoEX_RegWrite  = ctrl_q.reg_write;
  assign bus.IDtoEX_MemtoReg  = ctrl_q.mem_to_reg;
  assign bus.IDtoEX_Branch    = ctrl_q.branch;
  assign bus.IDtoEX_valid     = valid_q;
  assign bus.stall_count      = stall_q;
  assign bus.flush_count      = flush_q;

endmodule
